jtag_shift_out_ctrl: RTL and testbench

- Read-side sequencer for the JTAG shift-out FIFO: prefetches words from the FIFO read port and serialises them LSB-first onto a TDO bit stream during a JTAG shift-DR session.
- Capture/shift/update events arrive as single-cycle strobes, already synchronised to clk by the TAP bridge.
- Each word is framed as one flag bit plus the data bits. Underflow is reported in-band (flag = 0) and counted.

---
 rtl/jtag_shift_out_ctrl.sv | 113 +++++++++++
 tb/tb_jtag_shift_out_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_out_ctrl.sv
// Read-side sequencer for the JTAG shift-out FIFO: prefetches one word ahead and
// serialises {data, flag} LSB-first onto tdo during a shift-DR session.
module jtag_shift_out_ctrl #(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    capture,
  input  logic                    shift_en,
  input  logic                    update,
  output logic                    tdo,
  output logic                    busy,
  output logic                    rd_en,
  input  logic [c_DATA_WIDTH-1:0] rd_data,
  input  logic                    rd_empty,
  output logic [c_CNT_WIDTH-1:0]  word_cnt,
  output logic [c_CNT_WIDTH-1:0]  underflow_cnt,
  output logic                    drop
);

  localparam int               IDX_W    = $clog2(c_DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(c_DATA_WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state;
  logic [c_DATA_WIDTH-1:0] nxt;
  logic                    nxt_vld;
  logic                    pend;
  logic [c_DATA_WIDTH:0]   slot;
  logic                    slot_vld;
  logic [IDX_W-1:0]        bit_idx;

  logic issue;
  logic do_update;
  logic do_capture;
  logic do_shift;
  logic boundary;
  logic do_load;

  function automatic logic [c_CNT_WIDTH-1:0] sat_inc(input logic [c_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Event decode: update outranks capture, capture outranks shift_en.
  always_comb begin
    issue      = enable & ~nxt_vld & ~pend & ~rd_empty & ~rst;
    do_update  = (state == SHIFT) & update;
    do_capture = capture & ~update;
    do_shift   = (state == SHIFT) & shift_en & ~update & ~capture;
    boundary   = do_shift & (bit_idx == LAST_IDX);
    do_load    = do_capture | boundary;
  end

  // The FIFO has no output register, so rd_en must be combinational to keep
  // the one-cycle read latency and never fire against a stale empty flag.
  assign rd_en = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      nxt_vld       <= 1'b0;
      pend          <= 1'b0;
      slot          <= '0;
      slot_vld      <= 1'b0;
      bit_idx       <= '0;
      tdo           <= 1'b0;
      busy          <= 1'b0;
      word_cnt      <= '0;
      underflow_cnt <= '0;
      drop          <= 1'b0;
    end else begin
      drop <= 1'b0;
      // pend and nxt_vld are never both set, so a word landing here can never
      // collide with the consume below; it simply waits for the next slot.
      if (pend) begin
        nxt     <= rd_data;
        nxt_vld <= 1'b1;
      end else if (do_load) begin
        nxt_vld <= 1'b0;
      end
      pend <= issue;

      if (do_update) begin
        state    <= IDLE;
        busy     <= 1'b0;
        tdo      <= 1'b0;
        drop     <= slot_vld;
        slot_vld <= 1'b0;
      end else if (do_load) begin
        if (boundary && slot_vld)
          word_cnt <= sat_inc(word_cnt);
        if (!nxt_vld)
          underflow_cnt <= sat_inc(underflow_cnt);
        // slot_vld means "real word not yet counted", so it doubles as the drop test.
        drop     <= do_capture & slot_vld;
        slot     <= nxt_vld ? {nxt, 1'b1} : '0;
        slot_vld <= nxt_vld;
        tdo      <= nxt_vld;
        bit_idx  <= '0;
        state    <= SHIFT;
        busy     <= 1'b1;
      end else if (do_shift) begin
        slot    <= slot >> 1;
        tdo     <= slot[1];
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtag_shift_out_ctrl.sv
// Bench for jtag_shift_out_ctrl: directed vector table, saturation sequences and
// randomized traffic against a bit-queue reference model with a queue-backed FIFO.
module tb_jtag_shift_out_ctrl;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          capture;
  logic          shift_en;
  logic          update;
  logic          tdo;
  logic          busy;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          rd_empty;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] underflow_cnt;
  logic          drop;

  jtag_shift_out_ctrl #(.c_DATA_WIDTH(W), .c_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .capture(capture), .shift_en(shift_en),
    .update(update), .tdo(tdo), .busy(busy), .rd_en(rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .word_cnt(word_cnt), .underflow_cnt(underflow_cnt), .drop(drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // FIFO model: one-cycle read latency, no output register.
  logic [W-1:0] fq[$];

  // Reference model: the word in flight is a queue of bits still to appear on tdo.
  bit           m_shift, m_pend, m_have, m_real, m_tdo, m_drop;
  logic [W-1:0] m_held;
  bit           m_bits[$];
  int           m_wc, m_uc;
  bit           smp_rden;

  typedef struct {
    bit r, en, pv; logic [W-1:0] pd; bit c, s, u;
    bit e_rden, e_tdo, e_busy, e_drop; int e_wc, e_uc;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_step(input bit c, s, u, rden, r, input logic [W-1:0] rdv);
    if (r) begin
      m_shift = 0; m_pend = 0; m_have = 0; m_real = 0; m_tdo = 0; m_drop = 0;
      m_wc = 0; m_uc = 0; m_bits.delete();
      return;
    end
    m_drop = 0;
    if (u) begin
      if (m_shift) begin
        m_drop = m_real; m_shift = 0; m_tdo = 0; m_real = 0; m_bits.delete();
      end
    end else if (c || (m_shift && s && m_bits.size() == 1)) begin
      if (c) m_drop = m_shift && m_real;
      else if (m_real) m_wc = sat(m_wc);
      m_bits.delete();
      if (m_have) begin
        m_bits.push_back(1'b1);
        for (int i = 0; i < W; i++) m_bits.push_back(m_held[i]);
        m_real = 1; m_have = 0;
      end else begin
        repeat (W + 1) m_bits.push_back(1'b0);
        m_real = 0; m_uc = sat(m_uc);
      end
      m_tdo = m_bits[0]; m_shift = 1;
    end else if (m_shift && s) begin
      void'(m_bits.pop_front());
      m_tdo = m_bits[0];
    end
    if (m_pend) begin
      m_held = rdv; m_have = 1; m_pend = 0;
    end else if (rden) begin
      m_pend = 1;
    end
  endtask

  task automatic fifo_push(input logic [W-1:0] d);
    fq.push_back(d);
    rd_empty = 1'b0;
  endtask

  // Drives one clock cycle: inputs just after a posedge, rd_en checked mid-cycle,
  // registered outputs checked 1 time unit after the next posedge.
  task automatic cyc(input bit r, en, c, s, u);
    bit e_rden;
    rst = r; enable = en; capture = c; shift_en = s; update = u;
    #4;
    e_rden   = en && !m_have && !m_pend && (fq.size() != 0) && !r;
    smp_rden = rd_en;
    chk("rd_en", rd_en, e_rden);
    @(posedge clk);
    model_step(c, s, u, e_rden, r, rd_data);
    #1;
    if (r) fq.delete();
    else if (smp_rden && fq.size() != 0) rd_data = fq.pop_front();
    rd_empty = (fq.size() == 0);
    chk("tdo", tdo, m_tdo);
    chk("busy", busy, m_shift);
    chk("drop", drop, m_drop);
    chk("word_cnt", word_cnt, m_wc);
    chk("underflow_cnt", underflow_cnt, m_uc);
  endtask

  function automatic void add(input bit r, en, pv, input logic [W-1:0] pd, input bit c, s, u,
                              input bit erd, etdo, ebusy, edrop, input int ewc, euc);
    tv.push_back('{r, en, pv, pd, c, s, u, erd, etdo, ebusy, edrop, ewc, euc});
  endfunction

  function automatic void fill_table();
    logic [W-1:0] a5 = 8'hA5;
    // 0xA5 single word, three-cycle prefetch wait
    add(1,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(1,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,1,8'hA5, 0,0,0, 1,0,0,0, 0,0);
    add(0,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 1,0,0, 0,1,1,0, 0,0);
    for (int i = 0; i < W; i++) add(0,1,0,0, 0,1,0, 0,a5[i],1,0, 0,0);
    add(0,1,0,0, 0,1,0, 0,0,1,0, 1,1);
    add(0,1,0,0, 0,0,1, 0,0,0,0, 1,1);
    // empty FIFO: filler slots only
    add(1,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 1,0,0, 0,0,1,0, 0,1);
    for (int i = 0; i < W; i++) add(0,1,0,0, 0,1,0, 0,0,1,0, 0,1);
    add(0,1,0,0, 0,1,0, 0,0,1,0, 0,2);
    add(0,1,0,0, 0,0,1, 0,0,0,0, 0,2);
    // 0x01 then 0xFF back-to-back, second read during first slot
    add(1,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,1,8'h01, 0,0,0, 1,0,0,0, 0,0);
    add(0,1,1,8'hFF, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 1,0,0, 0,1,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 1,1,1,0, 0,0);
    for (int i = 1; i < W; i++) add(0,1,0,0, 0,1,0, 0,0,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 0,1,1,0, 1,0);
    for (int i = 0; i < W; i++) add(0,1,0,0, 0,1,0, 0,1,1,0, 1,0);
    add(0,1,0,0, 0,1,0, 0,0,1,0, 2,1);
    add(0,1,0,0, 0,0,1, 0,0,0,0, 2,1);
    // partial word then update -> drop; next capture gets the next word
    add(1,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,1,8'h11, 0,0,0, 1,0,0,0, 0,0);
    add(0,1,1,8'h22, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 1,0,0, 0,1,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 1,1,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 0,0,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 0,0,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 0,0,1,0, 0,0);
    add(0,1,0,0, 0,0,1, 0,0,0,1, 0,0);
    add(0,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 1,0,0, 0,1,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 0,0,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 0,1,1,0, 0,0);
    add(0,1,0,0, 0,0,1, 0,0,0,1, 0,0);
    // priority: capture+shift in IDLE, update+shift and update+capture in SHIFT
    add(1,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,1,8'h02, 0,0,0, 1,0,0,0, 0,0);
    add(0,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 1,1,0, 0,1,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 0,0,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 0,1,1,0, 0,0);
    add(0,1,0,0, 0,1,1, 0,0,0,1, 0,0);
    add(0,1,0,0, 1,0,0, 0,0,1,0, 0,1);
    add(0,1,0,0, 1,0,1, 0,0,0,0, 0,1);
    // reset mid-session with a read in flight, then enable gating
    add(1,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,1,8'h33, 0,0,0, 1,0,0,0, 0,0);
    add(0,1,1,8'h44, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 1,0,0, 0,1,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 1,1,1,0, 0,0);
    add(1,1,0,0, 0,1,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,0,1,8'h55, 0,0,0, 0,0,0,0, 0,0);
    add(0,0,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 0,0,0, 1,0,0,0, 0,0);
    add(0,1,0,0, 0,0,0, 0,0,0,0, 0,0);
    add(0,1,0,0, 1,0,0, 0,1,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 0,1,1,0, 0,0);
    add(0,1,0,0, 0,1,0, 0,0,1,0, 0,0);
    add(0,1,0,0, 0,0,1, 0,0,0,1, 0,0);
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; capture = 1'b0; shift_en = 1'b0; update = 1'b0;
    rd_data = '0; rd_empty = 1'b1;
    @(posedge clk);
    #1;

    fill_table();
    foreach (tv[i]) begin
      if (tv[i].pv) fifo_push(tv[i].pd);
      cyc(tv[i].r, tv[i].en, tv[i].c, tv[i].s, tv[i].u);
      chk($sformatf("tbl%0d_rd_en", i), smp_rden, tv[i].e_rden);
      chk($sformatf("tbl%0d_tdo", i), tdo, tv[i].e_tdo);
      chk($sformatf("tbl%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("tbl%0d_drop", i), drop, tv[i].e_drop);
      chk($sformatf("tbl%0d_word_cnt", i), word_cnt, tv[i].e_wc);
      chk($sformatf("tbl%0d_underflow_cnt", i), underflow_cnt, tv[i].e_uc);
    end

    // underflow counter saturation: 16 filler slots
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    repeat (15) repeat (W + 1) cyc(0, 1, 0, 1, 0);
    chk("underflow_sat", underflow_cnt, CMAX);
    cyc(0, 1, 0, 0, 1);

    // word counter saturation: 17 real words, then one filler
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) fifo_push(W'(i * 7 + 3));
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    repeat (17) repeat (W + 1) cyc(0, 1, 0, 1, 0);
    chk("word_sat", word_cnt, CMAX);
    chk("word_sat_uc", underflow_cnt, 1);
    cyc(0, 1, 0, 0, 1);

    // randomized traffic against the model
    cyc(1, 1, 0, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 99) < 30 && fq.size() < 6) fifo_push(W'($urandom));
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
